// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants for the 16-bit CPU: register-address width, forwarding-mux
// encodings and the ALU Y mux encodings, plus the forwarding priority helper.
package cpu_pipe_pkg;

  localparam int REG_AW = 3;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  localparam logic ALU_Y_REG = 1'b1;
  localparam logic ALU_Y_IMM = 1'b0;

  // Youngest producer wins: EX/MEM result beats MEM/WB result.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REGFILE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Combinational tag comparator: flags when a used source register is produced by a
// valid, writing instruction held in one pipeline stage.
module fwd_match #(
  parameter int REG_AW             = 3,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              t_valid,
  input  logic              t_wr,
  input  logic [REG_AW-1:0] t_rd,
  output logic              hit
);

  logic zero_dest_s;

  assign zero_dest_s = ZERO_REG_HARDWIRED && (t_rd == {REG_AW{1'b0}});
  assign hit         = use_src & t_valid & t_wr & (src == t_rd) & ~zero_dest_s;

endmodule

// File: rtl/alu_operand_ctrl.sv
// EX-stage operand mux controller: tracks EX/MEM/WB destination tags, registers the
// forwarding and ALU Y selects, and raises a one-cycle load-use stall.
// Optional feature macro: ALU_OPERAND_CTRL_PERF_EN adds the saturating stall_count output.
module alu_operand_ctrl #(
  parameter int REG_AW             = cpu_pipe_pkg::REG_AW,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_use_imm,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic              ex_alu_y_sel
`ifdef ALU_OPERAND_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  import cpu_pipe_pkg::*;

  logic              ex_valid_r;
  logic              ex_wr_r;
  logic              ex_load_r;
  logic [REG_AW-1:0] ex_rd_r;

  // Index 0 is the MEM stage, index 1 the WB stage (WB kept for debug visibility).
  logic              post_valid_r [2];
  logic              post_wr_r    [2];
  logic [REG_AW-1:0] post_rd_r    [2];

  logic       a_ex_hit_s, a_mem_hit_s, b_ex_hit_s, b_mem_hit_s;
  logic       stall_s;
  logic       bubble_s;
  logic [1:0] fwd_a_nxt_s;
  logic [1:0] fwd_b_nxt_s;
  logic       alu_y_nxt_s;

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_a_ex (
    .src(id_rs), .use_src(id_use_rs), .t_valid(ex_valid_r), .t_wr(ex_wr_r),
    .t_rd(ex_rd_r), .hit(a_ex_hit_s));

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_a_mem (
    .src(id_rs), .use_src(id_use_rs), .t_valid(post_valid_r[0]), .t_wr(post_wr_r[0]),
    .t_rd(post_rd_r[0]), .hit(a_mem_hit_s));

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_b_ex (
    .src(id_rt), .use_src(id_use_rt), .t_valid(ex_valid_r), .t_wr(ex_wr_r),
    .t_rd(ex_rd_r), .hit(b_ex_hit_s));

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_b_mem (
    .src(id_rt), .use_src(id_use_rt), .t_valid(post_valid_r[0]), .t_wr(post_wr_r[0]),
    .t_rd(post_rd_r[0]), .hit(b_mem_hit_s));

  // A load sitting in EX cannot forward yet; flush kills the consumer, so it wins.
  assign stall_s  = id_valid & ex_load_r & (a_ex_hit_s | b_ex_hit_s) & ~flush;
  assign stall    = stall_s;
  assign bubble_s = flush | stall_s | ~id_valid;

  // Next-cycle select values; a bubble drives every select to its idle encoding.
  always_comb begin
    fwd_a_nxt_s = FWD_REGFILE;
    fwd_b_nxt_s = FWD_REGFILE;
    alu_y_nxt_s = ALU_Y_IMM;
    if (bubble_s) begin
      fwd_a_nxt_s = FWD_REGFILE;
      fwd_b_nxt_s = FWD_REGFILE;
      alu_y_nxt_s = ALU_Y_IMM;
    end else begin
      fwd_a_nxt_s = fwd_sel(a_ex_hit_s, a_mem_hit_s);
      fwd_b_nxt_s = fwd_sel(b_ex_hit_s, b_mem_hit_s);
      alu_y_nxt_s = id_use_imm ? ALU_Y_IMM : ALU_Y_REG;
    end
  end

  // Stage tag tracker and registered select outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_wr_r      <= 1'b0;
      ex_load_r    <= 1'b0;
      ex_rd_r      <= {REG_AW{1'b0}};
      for (int i = 0; i < 2; i++) begin
        post_valid_r[i] <= 1'b0;
        post_wr_r[i]    <= 1'b0;
        post_rd_r[i]    <= {REG_AW{1'b0}};
      end
      ex_fwd_a_sel <= FWD_REGFILE;
      ex_fwd_b_sel <= FWD_REGFILE;
      ex_alu_y_sel <= ALU_Y_IMM;
    end else begin
      post_valid_r[0] <= ex_valid_r;
      post_wr_r[0]    <= ex_wr_r;
      post_rd_r[0]    <= ex_rd_r;
      post_valid_r[1] <= post_valid_r[0];
      post_wr_r[1]    <= post_wr_r[0];
      post_rd_r[1]    <= post_rd_r[0];
      if (bubble_s) begin
        ex_valid_r <= 1'b0;
        ex_wr_r    <= 1'b0;
        ex_load_r  <= 1'b0;
        ex_rd_r    <= {REG_AW{1'b0}};
      end else begin
        ex_valid_r <= 1'b1;
        ex_wr_r    <= id_wr_en;
        ex_load_r  <= id_is_load;
        ex_rd_r    <= id_rd;
      end
      ex_fwd_a_sel <= fwd_a_nxt_s;
      ex_fwd_b_sel <= fwd_b_nxt_s;
      ex_alu_y_sel <= alu_y_nxt_s;
    end
  end

`ifdef ALU_OPERAND_CTRL_PERF_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of real stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
`endif

endmodule
